// File: rtl/vae_pkg.sv
// vae_pkg: FSM states, LFSR taps/seed and eps constants shared by the latent sampler
package vae_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, CALC, HOLD} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int EPS_MUL = 7;
  localparam int EPS_OFFSET = 510;
  localparam int DRAW_CYCLES = 4;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/sigma_lut.sv
// sigma_lut: combinational ROM, sigma = round(exp(k/2) * 2^FRAC) saturated to 2^(WIDTH-1)-1
//   k     in  4-bit signed integer part of logvar, already clamped to -8..7
//   sigma out WIDTH-bit non-negative Q.FRAC standard deviation
module sigma_lut
  import vae_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int FRAC = 5
)(
  input  logic signed [3:0]  k,
  output logic [WIDTH-1:0]   sigma
);
  // sqrt(e) and 1/sqrt(e) in Q24; exp(k/2) is built by repeated multiplication at elaboration
  localparam longint SQRT_E = 64'd27660953;
  localparam longint RSQRT_E = 64'd10175896;
  localparam longint ONE = 64'd1 << 24;
  localparam longint SMAX = (64'd1 << (WIDTH - 1)) - 1;
  function automatic logic [WIDTH-1:0] entry(input int kk);
    longint v;
    v = ONE;
    for (int j = 0; j < (kk < 0 ? -kk : kk); j++)
      v = (v * (kk < 0 ? RSQRT_E : SQRT_E) + ONE / 2) >>> 24;
    v = ((v << FRAC) + ONE / 2) >>> 24;
    return WIDTH'(v > SMAX ? SMAX : v);
  endfunction
  logic [WIDTH-1:0] rom [16];
  for (genvar g = 0; g < 16; g++) begin : g_rom
    assign rom[g] = entry(g < 8 ? g : g - 16);
  end
  assign sigma = rom[$unsigned(k)];
endmodule

// File: rtl/latent_sampler.sv
// latent_sampler: VAE reparameterisation z = mu + exp(logvar/2) * eps, held for the decoder
//   clk, rst (async, active-high); start / sample_en / mu / logvar captured in IDLE
//   dec_finish releases HOLD; z is the latent vector, dec_enable high in HOLD, busy in DRAW/CALC
module latent_sampler
  import vae_pkg::*;
#(
  parameter int LATENT_NUM = 2,
  parameter int WIDTH = 10,
  parameter int FRAC = 5,
  parameter logic [15:0] SEED = 16'hACE1
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sample_en,
  input  logic [LATENT_NUM-1:0][WIDTH-1:0]  mu,
  input  logic [LATENT_NUM-1:0][WIDTH-1:0]  logvar,
  input  logic                              dec_finish,
  output logic [LATENT_NUM-1:0][WIDTH-1:0]  z,
  output logic                              dec_enable,
  output logic                              busy
);
  localparam int IW = LATENT_NUM > 1 ? $clog2(LATENT_NUM) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [15:0] SEED_Q = SEED == 16'd0 ? DEFAULT_SEED : SEED;
  localparam logic [IW-1:0] LAST = IW'(LATENT_NUM - 1);
  localparam logic signed [PW:0] ZMAX = (PW + 1)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [PW:0] ZMIN = (PW + 1)'(-(1 << (WIDTH - 1)));
  localparam logic signed [WIDTH-1:0] KMAX = WIDTH'(7);
  localparam logic signed [WIDTH-1:0] KMIN = WIDTH'(-8);
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [1:0] r_draw_cnt;
  logic [9:0] r_acc;
  logic [15:0] r_lfsr;
  logic [LATENT_NUM-1:0][WIDTH-1:0] r_mu, r_lv, r_z;
  logic r_se;
  logic signed [WIDTH-1:0] w_mu, w_lv_int;
  logic signed [3:0] w_k;
  logic [WIDTH-1:0] w_sigma, w_z;
  logic signed [13:0] w_e;
  logic signed [PW-1:0] w_eps, w_p;
  logic signed [PW:0] w_t;
  sigma_lut #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sigma (.k(w_k), .sigma(w_sigma));
  assign w_mu = $signed(r_mu[r_idx]);
  assign w_lv_int = $signed(r_lv[r_idx]) >>> FRAC;
  assign w_k = w_lv_int > KMAX ? 4'b0111 : w_lv_int < KMIN ? 4'b1000 : w_lv_int[3:0];
  // sum of four bytes is centred at 510; scale by 7 and drop bits so the result is Q.FRAC
  assign w_e = (($signed({4'd0, r_acc}) - 14'(EPS_OFFSET)) * 14'(EPS_MUL)) >>> (10 - FRAC);
  assign w_eps = r_se ? PW'(w_e) : '0;
  assign w_p = PW'($signed({1'b0, w_sigma})) * w_eps;
  assign w_t = (PW + 1)'(w_mu) + (PW + 1)'(w_p >>> FRAC);
  assign w_z = w_t > ZMAX ? ZMAX[WIDTH-1:0] : w_t < ZMIN ? ZMIN[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign z = r_z;
  assign dec_enable = r_state == HOLD;
  assign busy = r_state == DRAW || r_state == CALC;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = start ? DRAW : IDLE;
      DRAW: w_next = r_draw_cnt == 2'(DRAW_CYCLES - 1) ? CALC : DRAW;
      CALC: w_next = r_idx == LAST ? HOLD : DRAW;
      HOLD: w_next = dec_finish ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_draw_cnt <= '0;
      r_acc <= '0;
      r_lfsr <= SEED_Q;
      r_mu <= '0;
      r_lv <= '0;
      r_se <= 1'b0;
      r_z <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_mu <= mu;
          r_lv <= logvar;
          r_se <= sample_en;
          r_idx <= '0;
          r_acc <= '0;
        end
        DRAW: begin
          r_acc <= r_acc + {2'b0, r_lfsr[7:0]};
          r_lfsr <= lfsr_next(r_lfsr);
          r_draw_cnt <= r_draw_cnt + 2'd1;
        end
        CALC: begin
          r_z[r_idx] <= w_z;
          if (r_idx != LAST) begin
            r_idx <= r_idx + IW'(1);
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_latent_sampler.sv
// tb_latent_sampler: randomized scenarios against a behavioural reparameterisation model
module tb_latent_sampler;
  localparam int N = 2, W = 10, F = 5;
  logic clk = 1'b0;
  logic rst, start, sample_en, dec_finish, dec_enable, busy;
  logic [N-1:0][W-1:0] mu, logvar, z;
  int tests = 0, fails = 0;
  logic [15:0] m_lfsr;
  int g_mu [N];
  int g_lv [N];
  int exp_z [N];
  always #5 clk = ~clk;
  latent_sampler #(.LATENT_NUM(N), .WIDTH(W), .FRAC(F), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .mu(mu), .logvar(logvar),
    .dec_finish(dec_finish), .z(z), .dec_enable(dec_enable), .busy(busy)
  );
  function automatic logic [15:0] m_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic int m_sigma(input int lv);
    int k, s;
    k = lv >>> F;
    k = k > 7 ? 7 : k < -8 ? -8 : k;
    s = int'($exp(k / 2.0) * (2.0 ** F));
    return s > 511 ? 511 : s;
  endfunction
  task automatic model_sample(input bit se);
    for (int i = 0; i < N; i++) begin
      int acc, e, t;
      acc = 0;
      for (int d = 0; d < 4; d++) begin
        acc += int'(m_lfsr[7:0]);
        m_lfsr = m_step(m_lfsr);
      end
      e = se ? ((acc - 510) * 7) >>> (10 - F) : 0;
      t = g_mu[i] + ((m_sigma(g_lv[i]) * e) >>> F);
      exp_z[i] = t > 511 ? 511 : t < -512 ? -512 : t;
    end
  endtask
  task automatic run_sample(input bit se, output int lat);
    for (int i = 0; i < N; i++) begin
      mu[i] = W'(g_mu[i]);
      logvar[i] = W'(g_lv[i]);
    end
    sample_en = se;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_sample(se);
    lat = 0;
    while (!dec_enable && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic finish_hold();
    dec_finish = 1'b1;
    @(posedge clk); #1;
    dec_finish = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sample_en = 1'b0; dec_finish = 1'b0; mu = '0; logvar = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = 16'hACE1;
    tests++; if (z !== '0) begin fails++; $display("FAIL reset_z: got %h expected 0", z); end
    tests++; if (dec_enable !== 1'b0) begin fails++; $display("FAIL reset_dec_enable: got %b expected 0", dec_enable); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask
  task automatic test_lfsr();
    logic [15:0] l;
    int zero_hits, first_ret;
    l = 16'hACE1; zero_hits = 0; first_ret = 0;
    for (int s = 1; s <= 65535; s++) begin
      l = m_step(l);
      if (l == 16'd0) zero_hits++;
      if (l == 16'hACE1 && first_ret == 0) first_ret = s;
    end
    tests++; if (zero_hits != 0) begin fails++; $display("FAIL lfsr_zero: got %0d zero states expected 0", zero_hits); end
    tests++; if (first_ret != 65535) begin fails++; $display("FAIL lfsr_period: got %0d expected 65535", first_ret); end
  endtask
  task automatic test_deterministic();
    int lat;
    g_mu[0] = 10; g_mu[1] = -20;
    for (int i = 0; i < N; i++) g_lv[i] = int'($urandom_range(1023)) - 512;
    run_sample(1'b0, lat);
    tests++; if (lat != 10) begin fails++; $display("FAIL det_latency: got %0d expected 10", lat); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL det_z[%0d]: got %0d expected %0d", i, $signed(z[i]), exp_z[i]); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL det_busy_hold: got %b expected 0", busy); end
    finish_hold();
  endtask
  task automatic test_handshake();
    int lat;
    for (int i = 0; i < N; i++) begin
      g_mu[i] = int'($urandom_range(400)) - 200;
      g_lv[i] = int'($urandom_range(200)) - 100;
      mu[i] = W'(g_mu[i]);
      logvar[i] = W'(g_lv[i]);
    end
    sample_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_sample(1'b1);
    mu = W'($urandom) * N;
    logvar = '1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hs_busy_draw: got %b expected 1", busy); end
    start = 1'b1; dec_finish = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dec_finish = 1'b0;
    lat = 1;
    while (!dec_enable && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (lat != 10) begin fails++; $display("FAIL hs_latency: got %0d expected 10", lat); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (dec_enable !== 1'b1) begin fails++; $display("FAIL hs_hold_start: got dec_enable %b expected 1", dec_enable); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL hs_z[%0d]: got %0d expected %0d", i, $signed(z[i]), exp_z[i]); end
    end
    finish_hold();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || dec_enable !== 1'b0) begin fails++; $display("FAIL hs_no_queue: got busy %b dec_enable %b expected 0 0", busy, dec_enable); end
    run_sample(1'b1, lat);
    tests++; if (lat != 10) begin fails++; $display("FAIL hs_latency2: got %0d expected 10", lat); end
    start = 1'b1; dec_finish = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dec_finish = 1'b0;
    tests++; if (dec_enable !== 1'b0) begin fails++; $display("FAIL hs_start_finish: got dec_enable %b expected 0", dec_enable); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hs_start_dropped: got busy %b expected 0", busy); end
  endtask
  task automatic test_golden();
    int lat, d;
    real sum, sumsq, mean, sd;
    sum = 0.0; sumsq = 0.0;
    for (int s = 0; s < 1000; s++) begin
      for (int i = 0; i < N; i++) begin
        g_mu[i] = int'($urandom_range(600)) - 300;
        g_lv[i] = 0;
      end
      run_sample(1'b1, lat);
      tests++; if (lat != 10) begin fails++; $display("FAIL golden_latency sample %0d: got %0d expected 10", s, lat); end
      for (int i = 0; i < N; i++) begin
        tests++;
        if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL golden_z[%0d] sample %0d: got %0d expected %0d", i, s, $signed(z[i]), exp_z[i]); end
        d = int'($signed(z[i])) - g_mu[i];
        sum += d;
        sumsq += real'(d) * real'(d);
      end
      finish_hold();
    end
    mean = sum / (1000.0 * N);
    sd = $sqrt(sumsq / (1000.0 * N) - mean * mean);
    tests++; if (mean < -4.0 || mean > 4.0) begin fails++; $display("FAIL golden_mean: got %f expected within +-4", mean); end
    tests++; if (sd < 28.0 || sd > 60.0) begin fails++; $display("FAIL golden_std: got %f expected 28..60", sd); end
  endtask
  task automatic test_sigma();
    int lat;
    for (int s = 0; s < 150; s++) begin
      for (int i = 0; i < N; i++) begin
        g_mu[i] = int'($urandom_range(1023)) - 512;
        g_lv[i] = int'($urandom_range(1023)) - 512;
      end
      run_sample(1'b1, lat);
      for (int i = 0; i < N; i++) begin
        tests++;
        if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL sigma_z[%0d] sample %0d lv %0d: got %0d expected %0d", i, s, g_lv[i], $signed(z[i]), exp_z[i]); end
      end
      finish_hold();
    end
  endtask
  task automatic test_saturation();
    int lat, hi, lo;
    hi = 0; lo = 0;
    g_mu[0] = 511; g_mu[1] = -512; g_lv[0] = 224; g_lv[1] = 224;
    for (int s = 0; s < 200; s++) begin
      run_sample(1'b1, lat);
      for (int i = 0; i < N; i++) begin
        tests++;
        if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL sat_z[%0d] sample %0d: got %0d expected %0d", i, s, $signed(z[i]), exp_z[i]); end
      end
      if ($signed(z[0]) == 511) hi++;
      if ($signed(z[1]) == -512) lo++;
      finish_hold();
    end
    tests++; if (hi == 0 || lo == 0) begin fails++; $display("FAIL sat_reached: got hi %0d lo %0d expected both nonzero", hi, lo); end
  endtask
  task automatic test_reset_mid();
    int lat;
    g_mu[0] = 100; g_mu[1] = -100; g_lv[0] = 0; g_lv[1] = 0;
    run_sample(1'b0, lat);
    finish_hold();
    sample_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++; if (z !== '0) begin fails++; $display("FAIL rstmid_z: got %h expected 0", z); end
    tests++; if (busy !== 1'b0 || dec_enable !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: got busy %b dec_enable %b expected 0 0", busy, dec_enable); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    g_mu[0] = -37; g_mu[1] = 58; g_lv[0] = 40; g_lv[1] = -70;
    run_sample(1'b1, lat);
    tests++; if (lat != 10) begin fails++; $display("FAIL rstmid_latency: got %0d expected 10", lat); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if ($signed(z[i]) !== exp_z[i]) begin fails++; $display("FAIL rstmid_z[%0d]: got %0d expected %0d", i, $signed(z[i]), exp_z[i]); end
    end
    finish_hold();
  endtask
  initial begin
    test_reset();
    test_lfsr();
    test_deterministic();
    test_handshake();
    test_golden();
    test_sigma();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
